instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit: the initiator that drives the combinational instruction ROM's word address and consumes the 16-bit instruction it returns. It buffers fetched instructions in a 2-entry prefetch queue and delivers them, tagged with their PC, to the decoder over a valid/ready handshake. A redirect port lets the execute stage steer fetch to a branch or jump target.

## Interface
Parameters:
- PC_W, 30, width of the word-indexed program counter; matches the ROM address width.
- RESET_PC, 0, first word address fetched after reset.
- ROM_DEPTH, 7, number of valid ROM words; fetch stops at this address.

Ports:
- sys_clk  in  1  single clock; all state updates on the rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- rom_pc  out  PC_W  word address to the ROM; equals the internal fetch PC.
- rom_instrution  in  16  ROM read data for rom_pc, same cycle (combinational read).
- redir_valid  in  1  one-cycle pulse requesting a redirect.
- redir_pc  in  PC_W  redirect target word address; sampled when redir_valid=1.
- dec_valid  out  1  queue head holds a valid instruction.
- dec_instr  out  16  queue head instruction.
- dec_pc  out  PC_W  word address of the queue head instruction.
- dec_ready  in  1  decoder accepts the head this cycle.
- fetch_done  out  1  fetch PC has reached ROM_DEPTH; no further ROM reads are captured.

## Operation
- State:
  - fetch PC register fpc.
  - 2-entry queue holding {instr, pc} pairs, with head pointer, tail pointer and count (0..2).
- Pop: occurs when dec_valid & dec_ready.
- Push: occurs when all of the following hold:
  - no redirect this cycle;
  - fpc < ROM_DEPTH;
  - count<2, or count==2 with a pop this cycle.
- On push:
  - write {rom_instrution, fpc} to the tail;
  - tail advances;
  - fpc <= fpc+1 (modulo 2^PC_W; no wrap in practice because of the ROM_DEPTH stop).
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged.
- Redirect (highest priority), when redir_valid=1:
  - count, head and tail clear to 0;
  - fpc <= redir_pc;
  - no push that cycle;
  - any pop that cycle is discarded with the queue.
- Redirect target out of range: redir_pc >= ROM_DEPTH is legal and leaves fetch_done=1 with the queue empty.
- fetch_done = (fpc >= ROM_DEPTH), combinational from fpc.
- dec_valid = (count != 0). dec_instr and dec_pc come from the head entry.
- Held head: while dec_valid=1 and dec_ready=0, dec_instr and dec_pc hold stable until a pop or a redirect.
- Queue states:
  - EMPTY (count 0): push only.
  - ONE (count 1): push, pop, or both.
  - FULL (count 2): push only together with a pop.

## Timing
- Reset values: fpc=RESET_PC, count=0, head=tail=0, dec_valid=0, rom_pc=RESET_PC, fetch_done=(RESET_PC>=ROM_DEPTH).
- Queue data registers are don't-care at reset. They must not be visible while dec_valid=0; drive dec_instr/dec_pc to 0 when empty.
- Fetch-to-decode latency: the instruction at rom_pc in cycle N appears on dec_instr in cycle N+1 when the queue was empty.
- Throughput: one instruction per cycle with dec_ready held high.
- Redirect latency:
  - redir_valid in cycle N gives rom_pc=redir_pc in cycle N+1;
  - the target instruction appears on dec_instr in cycle N+2;
  - dec_valid=0 in cycle N+1.
- Reset mid-operation: asynchronous return to the reset values above; the queue is emptied immediately.

## Structure
- Shared package (cpu_pkg):
  - INSTR_W=16;
  - a fetch-entry typedef {instr[15:0], pc[PC_W-1:0]};
  - the decoder handshake field widths.
- Natural sub-module: fetch_queue, a 2-entry synchronous FIFO with flush.
  - Ports: push, pop, flush, wdata, rdata, count.
  - instr_fetch holds fpc, the push/pop decision and redirect priority.

## Test plan
- Reset, then dec_ready=1 with the ROM loaded with words W0..W6:
  - dec_valid rises on the first edge after reset release;
  - dec_pc runs 0,1,…,6 on consecutive cycles with matching W words;
  - fetch_done=1 once fpc=7, and dec_valid drops after W6 is popped.
- dec_ready=0 from reset:
  - count saturates at 2 and rom_pc holds at 2;
  - dec_instr stays W0 stable;
  - releasing dec_ready pops W0,W1,W2 back-to-back with no bubble.
- Redirect with the queue full (rom_pc=2) and redir_valid with redir_pc=5:
  - next cycle dec_valid=0 and rom_pc=5;
  - the cycle after, dec_pc=5 and dec_instr=W5.
- Redirect coincident with dec_ready=1 and a head present: the head is not delivered twice, and the next delivered dec_pc equals redir_pc.
- redir_pc=9 (>= ROM_DEPTH): fetch_done=1 and dec_valid stays 0 indefinitely; a later redirect to 0 resumes with W0.
- Assert sys_rst asynchronously between edges while count=2:
  - dec_valid=0 and rom_pc=0 immediately, without waiting for a clock edge;
  - normal fetch resumes after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, fetch entry layout and
// decoder handshake field widths.
package cpu_pkg;

   localparam int INSTR_W    = 16;
   localparam int FETCH_PC_W = 30;
   localparam int Q_DEPTH    = 2;

   localparam int DEC_INSTR_W = INSTR_W;
   localparam int DEC_PC_W    = FETCH_PC_W;

   typedef struct packed {
      logic [INSTR_W-1:0]    instr;
      logic [FETCH_PC_W-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO with flush; head is zeroed when empty
// so stale entries never reach the decoder.
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int DATA_W = $bits(fetch_entry_t)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic [1:0]        count
);

   logic [DATA_W-1:0] mem [Q_DEPTH];
   logic              head;
   logic              tail;
   logic              do_pop;
   logic              do_push;

   assign do_pop  = pop && (count != 2'd0);
   // When full, the slot being popped is the one the push reuses.
   assign do_push = push && ((count != 2'd2) || do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= 1'b0;
         tail  <= 1'b0;
         count <= 2'd0;
      end else if (flush) begin
         head  <= 1'b0;
         tail  <= 1'b0;
         count <= 2'd0;
      end else begin
         if (do_push) tail <= ~tail;
         if (do_pop)  head <= ~head;
         if (do_push && !do_pop)
            count <= count + 2'd1;
         else if (do_pop && !do_push)
            count <= count - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!flush && do_push)
         mem[tail] <= wdata;
   end

   assign rdata = (count != 2'd0) ? mem[head] : '0;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: drives the ROM address, prefetches into a
// 2-entry queue and hands {instr, pc} to the decoder.
module instr_fetch
   import cpu_pkg::*;
#(
   parameter int              PC_W      = 30,
   parameter logic [PC_W-1:0] RESET_PC  = '0,
   parameter int              ROM_DEPTH = 7
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   output logic [PC_W-1:0]    rom_pc,
   input  logic [INSTR_W-1:0] rom_instrution,
   input  logic               redir_valid,
   input  logic [PC_W-1:0]    redir_pc,
   output logic               dec_valid,
   output logic [INSTR_W-1:0] dec_instr,
   output logic [PC_W-1:0]    dec_pc,
   input  logic               dec_ready,
   output logic               fetch_done
);

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc;
   } entry_t;

   localparam logic [PC_W-1:0] DEPTH = PC_W'(ROM_DEPTH);

   logic [PC_W-1:0] fpc;
   logic [1:0]      count;
   logic            push;
   logic            pop;
   entry_t          wentry;
   entry_t          rentry;

   assign fetch_done = (fpc >= DEPTH);
   assign pop        = dec_valid && dec_ready;
   // Redirect wins: no push, and the queue flush discards any pop.
   assign push       = !redir_valid && !fetch_done &&
                       ((count != 2'd2) || pop);

   assign wentry.instr = rom_instrution;
   assign wentry.pc    = fpc;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst)
         fpc <= RESET_PC;
      else if (redir_valid)
         fpc <= redir_pc;
      else if (push)
         fpc <= fpc + 1'b1;
   end

   fetch_queue #(
      .DATA_W ($bits(entry_t))
   ) u_queue (
      .clk   (sys_clk),
      .rst   (sys_rst),
      .push  (push),
      .pop   (pop),
      .flush (redir_valid),
      .wdata (wentry),
      .rdata (rentry),
      .count (count)
   );

   assign rom_pc    = fpc;
   assign dec_valid = (count != 2'd0);
   assign dec_instr = rentry.instr;
   assign dec_pc    = rentry.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch with a 7-word combinational ROM
// model; word i holds 16'h1111*(i+1).
module tb_instr_fetch;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic [29:0] rom_pc;
   logic [15:0] rom_instrution;
   logic        redir_valid;
   logic [29:0] redir_pc;
   logic        dec_valid;
   logic [15:0] dec_instr;
   logic [29:0] dec_pc;
   logic        dec_ready;
   logic        fetch_done;

   int checks = 0;
   int errors = 0;

   always #5 sys_clk = ~sys_clk;

   function automatic logic [15:0] w(input int i);
      return 16'(16'h1111 * (i + 1));
   endfunction

   assign rom_instrution = (rom_pc < 30'd7) ? w(int'(rom_pc)) : 16'hFFFF;

   instr_fetch #(
      .PC_W      (30),
      .RESET_PC  (30'd0),
      .ROM_DEPTH (7)
   ) dut (
      .sys_clk        (sys_clk),
      .sys_rst        (sys_rst),
      .rom_pc         (rom_pc),
      .rom_instrution (rom_instrution),
      .redir_valid    (redir_valid),
      .redir_pc       (redir_pc),
      .dec_valid      (dec_valid),
      .dec_instr      (dec_instr),
      .dec_pc         (dec_pc),
      .dec_ready      (dec_ready),
      .fetch_done     (fetch_done)
   );

   task automatic do_reset(input logic rdy);
      @(negedge sys_clk);
      sys_rst     = 1'b1;
      redir_valid = 1'b0;
      redir_pc    = '0;
      dec_ready   = rdy;
      @(negedge sys_clk);
      @(negedge sys_clk);
      sys_rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge sys_clk);
      sys_rst     = 1'b1;
      redir_valid = 1'b0;
      redir_pc    = '0;
      dec_ready   = 1'b1;
      @(negedge sys_clk);
      checks++;
      if (dec_valid !== 1'b0 || rom_pc !== 30'd0 || fetch_done !== 1'b0 ||
          dec_instr !== 16'd0 || dec_pc !== 30'd0) begin
         errors++;
         $display("FAIL reset: valid=%b pc=%0d done=%b instr=%h dpc=%0d, want 0 0 0 0 0",
                  dec_valid, rom_pc, fetch_done, dec_instr, dec_pc);
      end
      sys_rst = 1'b0;
   endtask

   task automatic test_stream();
      for (int i = 0; i < 7; i++) begin
         @(negedge sys_clk);
         checks++;
         if (dec_valid !== 1'b1 || dec_pc !== 30'(i) || dec_instr !== w(i)) begin
            errors++;
            $display("FAIL stream[%0d]: valid=%b pc=%0d instr=%h, want 1 %0d %h",
                     i, dec_valid, dec_pc, dec_instr, i, w(i));
         end
         if (i == 6) begin
            checks++;
            if (fetch_done !== 1'b1 || rom_pc !== 30'd7) begin
               errors++;
               $display("FAIL stream_done: done=%b rom_pc=%0d, want 1 7",
                        fetch_done, rom_pc);
            end
         end
      end
      @(negedge sys_clk);
      checks++;
      if (dec_valid !== 1'b0 || dec_instr !== 16'd0 || fetch_done !== 1'b1) begin
         errors++;
         $display("FAIL stream_drain: valid=%b instr=%h done=%b, want 0 0000 1",
                  dec_valid, dec_instr, fetch_done);
      end
   endtask

   task automatic test_backpressure();
      do_reset(1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge sys_clk);
         checks++;
         if (dec_valid !== 1'b1 || dec_instr !== w(0) || dec_pc !== 30'd0) begin
            errors++;
            $display("FAIL hold[%0d]: valid=%b instr=%h pc=%0d, want 1 %h 0",
                     i, dec_valid, dec_instr, dec_pc, w(0));
         end
      end
      checks++;
      if (rom_pc !== 30'd2) begin
         errors++;
         $display("FAIL hold_rom_pc: got %0d want 2", rom_pc);
      end
      dec_ready = 1'b1;
      for (int i = 1; i < 4; i++) begin
         @(negedge sys_clk);
         checks++;
         if (dec_valid !== 1'b1 || dec_pc !== 30'(i) || dec_instr !== w(i)) begin
            errors++;
            $display("FAIL release[%0d]: valid=%b pc=%0d instr=%h, want 1 %0d %h",
                     i, dec_valid, dec_pc, dec_instr, i, w(i));
         end
      end
   endtask

   task automatic test_redirect_full();
      do_reset(1'b0);
      repeat (3) @(negedge sys_clk);
      checks++;
      if (rom_pc !== 30'd2 || dec_pc !== 30'd0) begin
         errors++;
         $display("FAIL rfull_pre: rom_pc=%0d dpc=%0d, want 2 0", rom_pc, dec_pc);
      end
      redir_valid = 1'b1;
      redir_pc    = 30'd5;
      @(negedge sys_clk);
      redir_valid = 1'b0;
      checks++;
      if (dec_valid !== 1'b0 || rom_pc !== 30'd5) begin
         errors++;
         $display("FAIL rfull_n1: valid=%b rom_pc=%0d, want 0 5", dec_valid, rom_pc);
      end
      @(negedge sys_clk);
      checks++;
      if (dec_valid !== 1'b1 || dec_pc !== 30'd5 || dec_instr !== w(5)) begin
         errors++;
         $display("FAIL rfull_n2: valid=%b pc=%0d instr=%h, want 1 5 %h",
                  dec_valid, dec_pc, dec_instr, w(5));
      end
   endtask

   task automatic test_redirect_pop();
      do_reset(1'b1);
      @(negedge sys_clk);
      @(negedge sys_clk);
      checks++;
      if (dec_valid !== 1'b1 || dec_pc !== 30'd1) begin
         errors++;
         $display("FAIL rpop_pre: valid=%b pc=%0d, want 1 1", dec_valid, dec_pc);
      end
      redir_valid = 1'b1;
      redir_pc    = 30'd3;
      @(negedge sys_clk);
      redir_valid = 1'b0;
      checks++;
      if (dec_valid !== 1'b0 || rom_pc !== 30'd3) begin
         errors++;
         $display("FAIL rpop_n1: valid=%b rom_pc=%0d, want 0 3", dec_valid, rom_pc);
      end
      for (int i = 3; i < 5; i++) begin
         @(negedge sys_clk);
         checks++;
         if (dec_valid !== 1'b1 || dec_pc !== 30'(i) || dec_instr !== w(i)) begin
            errors++;
            $display("FAIL rpop_next[%0d]: valid=%b pc=%0d instr=%h, want 1 %0d %h",
                     i, dec_valid, dec_pc, dec_instr, i, w(i));
         end
      end
   endtask

   task automatic test_redirect_oor();
      @(negedge sys_clk);
      redir_valid = 1'b1;
      redir_pc    = 30'd9;
      @(negedge sys_clk);
      redir_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (fetch_done !== 1'b1 || dec_valid !== 1'b0 || rom_pc !== 30'd9) begin
            errors++;
            $display("FAIL oor[%0d]: done=%b valid=%b rom_pc=%0d, want 1 0 9",
                     i, fetch_done, dec_valid, rom_pc);
         end
         @(negedge sys_clk);
      end
      redir_valid = 1'b1;
      redir_pc    = 30'd0;
      @(negedge sys_clk);
      redir_valid = 1'b0;
      checks++;
      if (fetch_done !== 1'b0 || dec_valid !== 1'b0 || rom_pc !== 30'd0) begin
         errors++;
         $display("FAIL oor_back_n1: done=%b valid=%b rom_pc=%0d, want 0 0 0",
                  fetch_done, dec_valid, rom_pc);
      end
      @(negedge sys_clk);
      checks++;
      if (dec_valid !== 1'b1 || dec_pc !== 30'd0 || dec_instr !== w(0)) begin
         errors++;
         $display("FAIL oor_back_n2: valid=%b pc=%0d instr=%h, want 1 0 %h",
                  dec_valid, dec_pc, dec_instr, w(0));
      end
   endtask

   task automatic test_async_reset();
      do_reset(1'b0);
      repeat (3) @(negedge sys_clk);
      checks++;
      if (dec_valid !== 1'b1 || rom_pc !== 30'd2) begin
         errors++;
         $display("FAIL areset_pre: valid=%b rom_pc=%0d, want 1 2", dec_valid, rom_pc);
      end
      #2;
      sys_rst = 1'b1;
      #1;
      checks++;
      if (dec_valid !== 1'b0 || rom_pc !== 30'd0 || dec_instr !== 16'd0) begin
         errors++;
         $display("FAIL areset_now: valid=%b rom_pc=%0d instr=%h, want 0 0 0000",
                  dec_valid, rom_pc, dec_instr);
      end
      @(negedge sys_clk);
      sys_rst   = 1'b0;
      dec_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge sys_clk);
         checks++;
         if (dec_valid !== 1'b1 || dec_pc !== 30'(i) || dec_instr !== w(i)) begin
            errors++;
            $display("FAIL areset_resume[%0d]: valid=%b pc=%0d instr=%h, want 1 %0d %h",
                     i, dec_valid, dec_pc, dec_instr, i, w(i));
         end
      end
   endtask

   initial begin
      sys_rst     = 1'b1;
      redir_valid = 1'b0;
      redir_pc    = '0;
      dec_ready   = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_full();
      test_redirect_pop();
      test_redirect_oor();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
